// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit: a four-state FSM that keeps at most one memory request
// outstanding, holds the fetched instruction for decode, and absorbs branch redirects.
module ysyx_22050710_ifu #(
    parameter int PC_WD   = 64,
    parameter int INST_WD = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PC_WD-1:0]   i_pc,
    output logic               o_pc_load,
    input  logic               i_flush,
    output logic               o_imem_req_valid,
    input  logic               i_imem_req_ready,
    output logic [PC_WD-1:0]   o_imem_addr,
    input  logic               i_imem_rsp_valid,
    input  logic [INST_WD-1:0] i_imem_rsp_data,
    output logic               o_id_valid,
    input  logic               i_id_ready,
    output logic [PC_WD-1:0]   o_id_pc,
    output logic [INST_WD-1:0] o_id_inst
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               drop_q, drop_d;
    logic [PC_WD-1:0]   fpc_q, fpc_d;
    logic [INST_WD-1:0] inst_q, inst_d;
    logic               hs_s;

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
            fpc_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            fpc_q   <= fpc_d;
            inst_q  <= inst_d;
        end
    end

    // Next-state logic and output decode
    always_comb begin
        state_d          = state_q;
        drop_d           = drop_q;
        fpc_d            = fpc_q;
        inst_d           = inst_q;
        o_imem_req_valid = (state_q == ST_REQ) && !i_rst;
        o_imem_addr      = i_pc;
        o_id_valid       = (state_q == ST_HOLD) && !i_rst;
        o_id_pc          = fpc_q;
        o_id_inst        = inst_q;
        hs_s             = o_imem_req_valid && i_imem_req_ready;
        o_pc_load        = !i_rst && (hs_s || i_flush);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (hs_s) begin
                    // A request accepted alongside a redirect is still in flight; mark it for discard
                    state_d = ST_WAIT;
                    if (i_flush) begin
                        drop_d = 1'b1;
                    end else begin
                        fpc_d = i_pc;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_imem_rsp_valid) begin
                    drop_d = 1'b0;
                    if (i_flush || drop_q) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                        inst_d  = i_imem_rsp_data;
                    end
                end else if (i_flush) begin
                    drop_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (i_flush || i_id_ready) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// Directed bench for the fetch unit; expected decode outputs come from a scoreboard
// queue filled when a response is driven and drained when decode accepts.
module tb_ysyx_22050710_ifu;

    logic        i_clk;
    logic        i_rst;
    logic [63:0] i_pc;
    logic        o_pc_load;
    logic        i_flush;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [63:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_id_valid;
    logic        i_id_ready;
    logic [63:0] o_id_pc;
    logic [31:0] o_id_inst;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    ysyx_22050710_ifu #(.PC_WD(64), .INST_WD(32)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_pc             (i_pc),
        .o_pc_load        (o_pc_load),
        .i_flush          (i_flush),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_id_valid       (o_id_valid),
        .i_id_ready       (i_id_ready),
        .o_id_pc          (o_id_pc),
        .o_id_inst        (o_id_inst)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One full fetch starting in REQ: optional request stall, response latency, decode stall
    task automatic fetch(input logic [63:0] pc, input int req_stall, input int rsp_lat,
                         input logic [31:0] data, input int id_stall, input bit flush_hold);
        exp_t e;
        i_pc = pc;
        i_imem_req_ready = 1'b0;
        for (int k = 0; k < req_stall; k++) begin
            #1;
            chk("req_valid_stall", {63'd0, o_imem_req_valid}, 64'd1);
            chk("addr_stall", o_imem_addr, pc);
            chk("pc_load_stall", {63'd0, o_pc_load}, 64'd0);
            tick();
        end
        i_imem_req_ready = 1'b1;
        #1;
        chk("req_valid_hs", {63'd0, o_imem_req_valid}, 64'd1);
        chk("addr_hs", o_imem_addr, pc);
        chk("pc_load_hs", {63'd0, o_pc_load}, 64'd1);
        tick();
        i_imem_req_ready = 1'b0;
        i_pc = pc + 64'd4;
        for (int k = 0; k < rsp_lat; k++) begin
            #1;
            chk("wait_req_valid", {63'd0, o_imem_req_valid}, 64'd0);
            chk("wait_pc_load", {63'd0, o_pc_load}, 64'd0);
            chk("wait_id_valid", {63'd0, o_id_valid}, 64'd0);
            tick();
        end
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = data;
        sb.push_back('{pc: pc, inst: data});
        #1;
        chk("rsp_pc_load", {63'd0, o_pc_load}, 64'd0);
        chk("rsp_req_valid", {63'd0, o_imem_req_valid}, 64'd0);
        tick();
        // Stray responses during HOLD must not disturb the held instruction
        i_imem_rsp_data = 32'hFFFF_FFFF;
        for (int k = 0; k < id_stall; k++) begin
            i_imem_rsp_valid = 1'b1;
            #1;
            chk("hold_id_valid", {63'd0, o_id_valid}, 64'd1);
            chk("hold_id_pc", o_id_pc, sb[0].pc);
            chk("hold_id_inst", {32'd0, o_id_inst}, {32'd0, sb[0].inst});
            chk("hold_req_valid", {63'd0, o_imem_req_valid}, 64'd0);
            chk("hold_pc_load", {63'd0, o_pc_load}, 64'd0);
            tick();
        end
        i_imem_rsp_valid = 1'b0;
        i_id_ready = 1'b1;
        i_flush = flush_hold;
        #1;
        e = sb.pop_front();
        chk("acc_id_valid", {63'd0, o_id_valid}, 64'd1);
        chk("acc_id_pc", o_id_pc, e.pc);
        chk("acc_id_inst", {32'd0, o_id_inst}, {32'd0, e.inst});
        chk("acc_pc_load", {63'd0, o_pc_load}, {63'd0, flush_hold});
        tick();
        i_id_ready = 1'b0;
        i_flush = 1'b0;
        #1;
        chk("after_acc_id_valid", {63'd0, o_id_valid}, 64'd0);
        chk("after_acc_req_valid", {63'd0, o_imem_req_valid}, 64'd1);
    endtask

    initial begin
        i_rst = 1'b1;
        i_pc = 64'd0;
        i_flush = 1'b0;
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data = 32'd0;
        i_id_ready = 1'b0;
        #1;
        chk("rst_pc_load", {63'd0, o_pc_load}, 64'd0);
        chk("rst_req_valid", {63'd0, o_imem_req_valid}, 64'd0);
        chk("rst_id_valid", {63'd0, o_id_valid}, 64'd0);
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        chk("post_rst_pc_load", {63'd0, o_pc_load}, 64'd0);
        chk("post_rst_req_valid", {63'd0, o_imem_req_valid}, 64'd0);
        chk("post_rst_id_valid", {63'd0, o_id_valid}, 64'd0);
        chk("post_rst_id_pc", o_id_pc, 64'd0);
        chk("post_rst_id_inst", {32'd0, o_id_inst}, 64'd0);
        tick();

        // Basic fetch, request stall, decode stall
        fetch(64'h8000_0000, 0, 0, 32'h0000_0013, 0, 1'b0);
        fetch(64'h8000_0004, 3, 0, 32'h0010_0093, 0, 1'b0);
        fetch(64'h8000_0008, 0, 1, 32'h0020_0113, 4, 1'b0);

        // Flush in WAIT; response two cycles later is discarded
        i_pc = 64'h8000_000C;
        i_imem_req_ready = 1'b1;
        tick();
        i_imem_req_ready = 1'b0;
        i_flush = 1'b1;
        i_pc = 64'h8000_0100;
        #1;
        chk("wflush_pc_load", {63'd0, o_pc_load}, 64'd1);
        tick();
        i_flush = 1'b0;
        #1;
        chk("wflush_gap_pc_load", {63'd0, o_pc_load}, 64'd0);
        chk("wflush_gap_id_valid", {63'd0, o_id_valid}, 64'd0);
        chk("wflush_gap_req_valid", {63'd0, o_imem_req_valid}, 64'd0);
        tick();
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data = 32'hDEAD_BEEF;
        #1;
        chk("wflush_rsp_pc_load", {63'd0, o_pc_load}, 64'd0);
        tick();
        i_imem_rsp_valid = 1'b0;
        #1;
        chk("wflush_drop_id_valid", {63'd0, o_id_valid}, 64'd0);
        chk("wflush_refetch_valid", {63'd0, o_imem_req_valid}, 64'd1);
        chk("wflush_refetch_addr", o_imem_addr, 64'h8000_0100);
        fetch(64'h8000_0100, 0, 0, 32'h0030_0193, 1, 1'b0);

        // Flush coincident with handshake: one pc_load, next response dropped
        i_pc = 64'h8000_0104;
        i_imem_req_ready = 1'b1;
        i_flush = 1'b1;
        #1;
        chk("hsflush_pc_load", {63'd0, o_pc_load}, 64'd1);
        tick();
        i_imem_req_ready = 1'b0;
        i_flush = 1'b0;
        i_pc = 64'h8000_0200;
        #1;
        chk("hsflush_no_second_load", {63'd0, o_pc_load}, 64'd0);
        chk("hsflush_wait_req_valid", {63'd0, o_imem_req_valid}, 64'd0);
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data = 32'h0BAD_0BAD;
        tick();
        i_imem_rsp_valid = 1'b0;
        #1;
        chk("hsflush_drop_id_valid", {63'd0, o_id_valid}, 64'd0);
        chk("hsflush_target_addr", o_imem_addr, 64'h8000_0200);
        chk("hsflush_target_valid", {63'd0, o_imem_req_valid}, 64'd1);
        // Fetch from target, then redirect while the instruction is held
        fetch(64'h8000_0200, 0, 0, 32'h0040_0213, 2, 1'b1);

        // Reset while waiting; late response in IDLE is ignored
        i_pc = 64'h8000_0300;
        i_imem_req_ready = 1'b1;
        tick();
        i_imem_req_ready = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("rst_wait_pc_load", {63'd0, o_pc_load}, 64'd0);
        chk("rst_wait_req_valid", {63'd0, o_imem_req_valid}, 64'd0);
        tick();
        i_rst = 1'b0;
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data = 32'h0000_1234;
        #1;
        chk("late_rsp_id_valid", {63'd0, o_id_valid}, 64'd0);
        chk("late_rsp_pc_load", {63'd0, o_pc_load}, 64'd0);
        chk("late_rsp_id_inst", {32'd0, o_id_inst}, 64'd0);
        tick();
        i_imem_rsp_valid = 1'b0;
        fetch(64'h8000_0400, 0, 2, 32'h0050_0293, 0, 1'b0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
